// File: rtl/fco_align_tracker.sv
// ---------------------------------------------------------------------------
// fco_align_tracker
//   Multi-lane frame-clock (FCO) alignment tracker. Each lane watches its FCO
//   sample for rising edges and checks that they arrive every expect_period
//   valid words. Lanes lock after LOCK_COUNT consecutive good frames. A locked
//   lane drops after UNLOCK_COUNT consecutive bad frames. While a lane is still
//   searching, a bad frame requests a deserializer bitslip. The lane then waits
//   SLIP_WAIT valid words before it searches again. Each lane keeps a
//   saturating count of bad frames.
//
// Ports
//   dco_clk         deserialized word clock
//   rst             asynchronous active-high reset
//   fco_in          per-lane frame clock sample
//   word_valid      common word strobe; lane logic advances only when high
//   expect_period   words per frame (values below 2 behave as 2)
//   clr_err         synchronous clear of every error counter
//   lane_aligned    per-lane LOCKED indication
//   all_aligned     registered AND of lane_aligned
//   bitslip         one-cycle slip request per lane
//   align_err_pulse one-cycle pulse per bad frame
//   err_count       saturating bad-frame counters, lane i at [i*ERR_W +: ERR_W]
// ---------------------------------------------------------------------------
module fco_align_tracker #(
  parameter int NUM_LANES    = 4,
  parameter int PERIOD_W     = 8,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2,
  parameter int SLIP_WAIT    = 8,
  parameter int ERR_W        = 16
) (
  input  logic                       dco_clk,
  input  logic                       rst,
  input  logic [NUM_LANES-1:0]       fco_in,
  input  logic                       word_valid,
  input  logic [PERIOD_W-1:0]        expect_period,
  input  logic                       clr_err,
  output logic [NUM_LANES-1:0]       lane_aligned,
  output logic                       all_aligned,
  output logic [NUM_LANES-1:0]       bitslip,
  output logic [NUM_LANES-1:0]       align_err_pulse,
  output logic [NUM_LANES*ERR_W-1:0] err_count
);

  // One extra bit so that "one word past the period" is representable even
  // at the largest programmable period.
  localparam int CNT_W  = PERIOD_W + 1;
  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);
  localparam int SLIP_W = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    TRACK     = 2'd1,
    SLIP_HOLD = 2'd2,
    LOCKED    = 2'd3
  } lane_state_t;

  logic [CNT_W-1:0] period;

  // The frame checks never use a period shorter than two words.
  always_comb begin
    period = {1'b0, expect_period};
    if (expect_period < PERIOD_W'(2)) period = CNT_W'(2);
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_state_t       state;
    logic [CNT_W-1:0]  words_since;
    logic [LOCK_W-1:0] streak;
    logic [MISS_W-1:0] miss;
    logic [SLIP_W-1:0] slip_cnt;
    logic [ERR_W-1:0]  err;
    logic              fco_d;
    logic              aligned_q;
    logic              slip_q;
    logic              err_pulse_q;
    logic              rise;
    logic              good;
    logic              bad;
    logic              checking;
    logic [CNT_W-1:0]  nw;
    logic [LOCK_W-1:0] streak_nxt;
    logic [MISS_W-1:0] miss_nxt;
    logic [SLIP_W-1:0] slip_nxt;

    // Frame classification for the current word. A missing edge is
    // recognised one word after the expected position.
    always_comb begin
      rise       = fco_in[i] & ~fco_d;
      nw         = words_since + CNT_W'(1);
      good       = rise && (nw == period);
      bad        = (rise && (nw != period)) || (!rise && (nw > period));
      checking   = (state == TRACK) || (state == LOCKED);
      streak_nxt = streak + LOCK_W'(1);
      miss_nxt   = miss + MISS_W'(1);
      slip_nxt   = slip_cnt + SLIP_W'(1);
    end

    // Lane state machine. Pulse outputs are cleared by default every cycle,
    // so they stay high for one cycle even when word_valid is low.
    always_ff @(posedge dco_clk or posedge rst) begin
      if (rst) begin
        state       <= SEARCH;
        words_since <= '0;
        streak      <= '0;
        miss        <= '0;
        slip_cnt    <= '0;
        fco_d       <= 1'b0;
        aligned_q   <= 1'b0;
        slip_q      <= 1'b0;
        err_pulse_q <= 1'b0;
      end else begin
        fco_d       <= fco_in[i];
        slip_q      <= 1'b0;
        err_pulse_q <= 1'b0;
        if (word_valid) begin
          unique case (state)
            SEARCH: begin
              if (rise) begin
                state       <= TRACK;
                words_since <= '0;
                streak      <= '0;
              end
            end
            TRACK: begin
              if (good) begin
                words_since <= '0;
                streak      <= streak_nxt;
                if (streak_nxt == LOCK_W'(LOCK_COUNT)) begin
                  state     <= LOCKED;
                  aligned_q <= 1'b1;
                  miss      <= '0;
                end
              end else if (bad) begin
                words_since <= '0;
                streak      <= '0;
                slip_cnt    <= '0;
                slip_q      <= 1'b1;
                err_pulse_q <= 1'b1;
                state       <= SLIP_HOLD;
              end else begin
                words_since <= nw;
              end
            end
            SLIP_HOLD: begin
              // FCO edges are ignored while the deserializer settles.
              if (slip_nxt == SLIP_W'(SLIP_WAIT)) state <= SEARCH;
              else slip_cnt <= slip_nxt;
            end
            LOCKED: begin
              if (good) begin
                words_since <= '0;
                miss        <= '0;
              end else if (bad) begin
                words_since <= '0;
                err_pulse_q <= 1'b1;
                miss        <= miss_nxt;
                // Losing lock goes straight back to SEARCH; no slip is requested.
                if (miss_nxt == MISS_W'(UNLOCK_COUNT)) begin
                  state     <= SEARCH;
                  aligned_q <= 1'b0;
                end
              end else begin
                words_since <= nw;
              end
            end
            default: state <= SEARCH;
          endcase
        end
      end
    end

    // Saturating error counter. A clear takes priority over an increment in
    // the same cycle.
    always_ff @(posedge dco_clk or posedge rst) begin
      if (rst) begin
        err <= '0;
      end else if (clr_err) begin
        err <= '0;
      end else if (word_valid && checking && bad && (err != {ERR_W{1'b1}})) begin
        err <= err + ERR_W'(1);
      end
    end

    assign lane_aligned[i]                = aligned_q;
    assign bitslip[i]                     = slip_q;
    assign align_err_pulse[i]             = err_pulse_q;
    assign err_count[i*ERR_W +: ERR_W]    = err;
  end

  // all_aligned trails the per-lane flags by one cycle.
  always_ff @(posedge dco_clk or posedge rst) begin
    if (rst) all_aligned <= 1'b0;
    else     all_aligned <= &lane_aligned;
  end

endmodule

// File: tb/tb_fco_align_tracker.sv
// ---------------------------------------------------------------------------
// tb_fco_align_tracker
//   Bench for fco_align_tracker. Two instances share all inputs: one with the
//   default 16-bit error counters and one with 4-bit counters so that
//   saturation is reachable. A reference model tracks frames by the absolute
//   valid-word index of the last frame boundary. Every cycle it is compared
//   with both instances. A table of scenarios with hand-derived end states
//   drives the main checks. Random segments follow.
// ---------------------------------------------------------------------------
module tb_fco_align_tracker;

  localparam int NL = 4;

  logic             dco_clk = 1'b0;
  logic             rst = 1'b0;
  logic [NL-1:0]    fco_in = '0;
  logic             word_valid = 1'b0;
  logic [7:0]       expect_period = 8'd16;
  logic             clr_err = 1'b0;

  logic [NL-1:0]    lane_aligned, bitslip, align_err_pulse;
  logic             all_aligned;
  logic [NL*16-1:0] err_count;
  logic [NL-1:0]    lane_aligned_s, bitslip_s, align_err_pulse_s;
  logic             all_aligned_s;
  logic [NL*4-1:0]  err_count_s;

  fco_align_tracker dut (
    .dco_clk(dco_clk), .rst(rst), .fco_in(fco_in), .word_valid(word_valid),
    .expect_period(expect_period), .clr_err(clr_err),
    .lane_aligned(lane_aligned), .all_aligned(all_aligned), .bitslip(bitslip),
    .align_err_pulse(align_err_pulse), .err_count(err_count)
  );

  fco_align_tracker #(.ERR_W(4)) dut_sat (
    .dco_clk(dco_clk), .rst(rst), .fco_in(fco_in), .word_valid(word_valid),
    .expect_period(expect_period), .clr_err(clr_err),
    .lane_aligned(lane_aligned_s), .all_aligned(all_aligned_s), .bitslip(bitslip_s),
    .align_err_pulse(align_err_pulse_s), .err_count(err_count_s)
  );

  always #5 dco_clk = ~dco_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  localparam int M_SEARCH = 0, M_TRACK = 1, M_SLIP = 2, M_LOCKED = 3;
  int            m_word;
  int            m_mode[NL];
  int            m_anchor[NL];
  int            m_good[NL];
  int            m_miss[NL];
  int            m_slip_start[NL];
  int            m_err[NL];
  logic [NL-1:0] m_prev_fco, m_aligned, m_slip, m_pulse;
  logic          m_all;

  // Stimulus generator: each lane raises FCO every gen_per valid words.
  int gen_cnt[NL];
  int gen_per[NL];

  // The model advances on each clock edge from the inputs the bench holds
  // steady around that edge.
  always @(posedge dco_clk or posedge rst) begin : model_step
    logic [NL-1:0] rise;
    int p, d;
    bit good, bad;
    if (rst) begin
      m_word = 0;
      m_prev_fco = '0; m_aligned = '0; m_slip = '0; m_pulse = '0; m_all = 1'b0;
      for (int l = 0; l < NL; l++) begin
        m_mode[l] = M_SEARCH; m_anchor[l] = 0; m_good[l] = 0;
        m_miss[l] = 0; m_slip_start[l] = 0; m_err[l] = 0;
      end
    end else begin
      rise = fco_in & ~m_prev_fco;
      m_prev_fco = fco_in;
      m_all = &m_aligned;
      m_slip = '0;
      m_pulse = '0;
      if (word_valid) begin
        m_word++;
        p = (expect_period < 2) ? 2 : int'(expect_period);
        for (int l = 0; l < NL; l++) begin
          d = m_word - m_anchor[l];
          good = rise[l] && (d == p);
          bad  = (rise[l] && (d != p)) || (!rise[l] && (d > p));
          case (m_mode[l])
            M_SEARCH: if (rise[l]) begin
              m_mode[l] = M_TRACK; m_anchor[l] = m_word; m_good[l] = 0;
            end
            M_TRACK: begin
              if (good) begin
                m_anchor[l] = m_word;
                m_good[l]++;
                if (m_good[l] == 4) begin
                  m_mode[l] = M_LOCKED; m_aligned[l] = 1'b1; m_miss[l] = 0;
                end
              end else if (bad) begin
                m_anchor[l] = m_word;
                m_slip[l] = 1'b1; m_pulse[l] = 1'b1; m_err[l]++;
                m_mode[l] = M_SLIP; m_slip_start[l] = m_word;
              end
            end
            M_SLIP: if (m_word - m_slip_start[l] == 8) m_mode[l] = M_SEARCH;
            default: begin
              if (good) begin
                m_anchor[l] = m_word; m_miss[l] = 0;
              end else if (bad) begin
                m_anchor[l] = m_word; m_pulse[l] = 1'b1; m_err[l]++; m_miss[l]++;
                if (m_miss[l] == 2) begin
                  m_mode[l] = M_SEARCH; m_aligned[l] = 1'b0;
                end
              end
            end
          endcase
        end
      end
      if (clr_err) for (int l = 0; l < NL; l++) m_err[l] = 0;
    end
  end

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    logic [63:0] e16, e4;
    logic [12:0] flags;
    e16 = '0; e4 = '0;
    for (int l = 0; l < NL; l++) begin
      e16[l*16 +: 16] = (m_err[l] > 65535) ? 16'hFFFF : 16'(m_err[l]);
      e4[l*4 +: 4]    = (m_err[l] > 15) ? 4'hF : 4'(m_err[l]);
    end
    flags = {m_aligned, m_all, m_slip, m_pulse};
    check_val("cycle_flags", 64'({lane_aligned, all_aligned, bitslip, align_err_pulse}), 64'(flags));
    check_val("cycle_flags_sat", 64'({lane_aligned_s, all_aligned_s, bitslip_s, align_err_pulse_s}), 64'(flags));
    check_val("cycle_err", err_count, e16);
    check_val("cycle_err_sat", 64'(err_count_s), e4);
  endtask

  task automatic tick(input logic [NL-1:0] f, input logic wv, input logic clr);
    fco_in = f; word_valid = wv; clr_err = clr;
    @(posedge dco_clk);
    #1;
    check_output();
  endtask

  task automatic apply_reset();
    rst = 1'b1; fco_in = '0; word_valid = 1'b0; clr_err = 1'b0;
    @(posedge dco_clk);
    #1;
    check_output();
    check_val("reset_flags", 64'({lane_aligned, all_aligned, bitslip, align_err_pulse}), 64'd0);
    check_val("reset_err", err_count, 64'd0);
    rst = 1'b0;
    for (int l = 0; l < NL; l++) gen_cnt[l] = 0;
  endtask

  // Runs n valid words. With rand_valid, idle cycles come in pairs. The first
  // idle cycle may carry injected FCO rises. The second idle cycle returns FCO
  // low, so the next valid word sees a clean edge.
  task automatic apply_stimulus(input int n, input bit rand_valid, input bit inject, input bit clr_last);
    int done;
    logic [NL-1:0] f;
    done = 0;
    while (done < n) begin
      if (rand_valid && ($urandom_range(1, 0) == 0)) begin
        f = inject ? NL'($urandom) : '0;
        tick(f, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0);
      end else begin
        f = '0;
        for (int l = 0; l < NL; l++) begin
          gen_cnt[l]++;
          if (gen_cnt[l] >= gen_per[l]) begin
            f[l] = 1'b1;
            gen_cnt[l] = 0;
          end
        end
        done++;
        tick(f, 1'b1, clr_last && (done == n));
      end
    end
  endtask

  typedef struct {
    logic             do_reset;
    logic [7:0]       ep;
    logic [3:0][7:0]  per;
    int               words;
    logic             rand_valid;
    logic             inject;
    logic [3:0]       exp_aligned;
    logic [3:0][15:0] exp_err;
    string            name;
  } vec_t;

  vec_t vecs[10];

  task automatic check_vector(input vec_t v);
    logic [15:0] e4;
    check_val({v.name, "_aligned"}, 64'(lane_aligned), 64'(v.exp_aligned));
    check_val({v.name, "_err"}, err_count, 64'(v.exp_err));
    for (int l = 0; l < NL; l++) e4[l*4 +: 4] = (v.exp_err[l] > 15) ? 4'hF : v.exp_err[l][3:0];
    check_val({v.name, "_err_sat"}, 64'(err_count_s), 64'(e4));
  endtask

  task automatic run_vector(input vec_t v);
    if (v.do_reset) apply_reset();
    expect_period = v.ep;
    for (int l = 0; l < NL; l++) gen_per[l] = int'(v.per[l]);
    apply_stimulus(v.words, v.rand_valid, v.inject, 1'b0);
    check_vector(v);
  endtask

  initial begin
    // Lane order in the literals below is {lane3, lane2, lane1, lane0}.
    vecs[0] = '{1'b1, 8'd16, {8'd16, 8'd16, 8'd16, 8'd16}, 96, 1'b0, 1'b0, 4'hF,
                {16'd0, 16'd0, 16'd0, 16'd0}, "clean16"};
    vecs[1] = '{1'b1, 8'd16, {8'd16, 8'd16, 8'd15, 8'd16}, 96, 1'b0, 1'b0, 4'b1101,
                {16'd0, 16'd0, 16'd3, 16'd0}, "lane1_p15"};
    vecs[2] = '{1'b0, 8'd16, {8'd16, 8'd16, 8'd16, 8'd16}, 128, 1'b0, 1'b0, 4'hF,
                {16'd0, 16'd0, 16'd3, 16'd0}, "lane1_fixed"};
    vecs[3] = '{1'b0, 8'd16, {8'd16, 8'd32, 8'd16, 8'd16}, 32, 1'b0, 1'b0, 4'b1011,
                {16'd0, 16'd2, 16'd3, 16'd0}, "lane2_unlock"};
    vecs[4] = '{1'b0, 8'd16, {8'd16, 8'd16, 8'd16, 8'd16}, 96, 1'b0, 1'b0, 4'hF,
                {16'd0, 16'd2, 16'd3, 16'd0}, "lane2_relock"};
    vecs[5] = '{1'b0, 8'd16, {8'd17, 8'd16, 8'd16, 8'd16}, 17, 1'b0, 1'b0, 4'hF,
                {16'd1, 16'd2, 16'd3, 16'd0}, "lane3_one_bad"};
    vecs[6] = '{1'b0, 8'd16, {8'd16, 8'd16, 8'd16, 8'd16}, 32, 1'b0, 1'b0, 4'hF,
                {16'd1, 16'd2, 16'd3, 16'd0}, "lane3_resync"};
    vecs[7] = '{1'b1, 8'd16, {8'd16, 8'd16, 8'd16, 8'd16}, 96, 1'b1, 1'b1, 4'hF,
                {16'd0, 16'd0, 16'd0, 16'd0}, "wv50_inject"};
    vecs[8] = '{1'b1, 8'd1, {8'd2, 8'd2, 8'd2, 8'd2}, 12, 1'b0, 1'b0, 4'hF,
                {16'd0, 16'd0, 16'd0, 16'd0}, "clamp_ep1"};
    vecs[9] = '{1'b1, 8'd2, {8'd3, 8'd3, 8'd3, 8'd3}, 300, 1'b0, 1'b0, 4'h0,
                {16'd25, 16'd25, 16'd25, 16'd25}, "err_sat"};

    #1;
    for (int i = 0; i < 7; i++) run_vector(vecs[i]);

    // Asynchronous reset in the middle of a cycle while every lane is locked.
    check_val("prelock", 64'({lane_aligned, all_aligned}), 64'h1F);
    #3 rst = 1'b1;
    #1;
    check_val("async_reset_flags", 64'({lane_aligned, all_aligned, bitslip, align_err_pulse}), 64'd0);
    check_val("async_reset_err", err_count, 64'd0);
    @(posedge dco_clk);
    #1;
    check_output();
    rst = 1'b0;

    for (int i = 7; i < 10; i++) run_vector(vecs[i]);

    // The next bad frame lands on word 306. Clearing on that same word must
    // leave every counter at zero while the pulses still fire.
    apply_stimulus(6, 1'b0, 1'b0, 1'b1);
    check_val("clr_beats_inc_err", err_count, 64'd0);
    check_val("clr_beats_inc_err_sat", 64'(err_count_s), 64'd0);
    check_val("clr_same_cycle_pulses", 64'({bitslip, align_err_pulse}), 64'hFF);

    // Random segments: expect_period changes on the fly, lane periods usually
    // match it, word_valid and injected idle-cycle rises vary.
    apply_reset();
    for (int s = 0; s < 24; s++) begin
      expect_period = 8'($urandom_range(20, 0));
      for (int l = 0; l < NL; l++)
        gen_per[l] = ($urandom_range(3, 0) != 0) ? ((expect_period < 2) ? 2 : int'(expect_period))
                                                  : int'($urandom_range(20, 2));
      apply_stimulus(int'($urandom_range(150, 40)), bit'($urandom_range(1, 0)), 1'b1,
                     bit'($urandom_range(3, 0) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
